// File: rtl/mem_config_pkg.sv
// Image memory geometry shared by the Sobel datapath and its loaders.
package mem_config_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
endpackage

// File: rtl/rgb2gray_loader_pkg.sv
// Datapath widths and helpers for the RGB-to-gray loader.
package rgb2gray_loader_pkg;
    import mem_config_pkg::*;

    localparam int PROD_WIDTH = DATA_WIDTH + 8;
    localparam int SUM_WIDTH  = DATA_WIDTH + 10;

    function automatic int weight_sum(input logic [7:0] w_r, input logic [7:0] w_g,
                                      input logic [7:0] w_b);
        return int'(w_r) + int'(w_g) + int'(w_b);
    endfunction
endpackage

// File: rtl/sobel_config_pkg.sv
// Frame geometry of the Sobel edge detector and the default grayscale weights.
package sobel_config_pkg;
    localparam int IMAGE_ROW_SIZE    = 4;
    localparam int IMAGE_COLUMN_SIZE = 4;
    localparam int PIX_COUNT         = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;

    localparam logic [7:0] GRAY_W_R = 8'd77;
    localparam logic [7:0] GRAY_W_G = 8'd150;
    localparam logic [7:0] GRAY_W_B = 8'd29;
endpackage

// File: rtl/rgb2gray_loader_if.sv
// Pixel stream into the loader: packed {R,G,B} beats with a last marker.
interface rgb2gray_loader_if;
    import mem_config_pkg::*;

    logic                      s_valid_i;
    logic                      s_ready_o;
    logic [3*DATA_WIDTH-1:0]   s_rgb_i;
    logic                      s_last_i;

    modport master (output s_valid_i, s_rgb_i, s_last_i, input s_ready_o);
    modport slave  (input s_valid_i, s_rgb_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/rgb2gray_pipe.sv
// Two-stage weighted-sum datapath: per-channel products, then sum and >>8.
module rgb2gray_pipe
    import mem_config_pkg::*;
    import rgb2gray_loader_pkg::*;
#(
    parameter logic [7:0] W_R = 8'd77,
    parameter logic [7:0] W_G = 8'd150,
    parameter logic [7:0] W_B = 8'd29
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid,
    input  logic [3*DATA_WIDTH-1:0] in_rgb,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    output logic                    s1_valid,
    output logic                    out_valid,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH-1:0]   out_data
);
    localparam logic [7:0] WEIGHTS [3] = '{W_R, W_G, W_B};

    logic [ADDR_WIDTH-1:0] s1_addr_reg;
    logic [SUM_WIDTH-1:0]  gray_sum;

    // Channel gi = 0 is R (MSBs), 2 is B (LSBs).
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [PROD_WIDTH-1:0] prod_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                prod_reg <= '0;
            end else begin
                prod_reg <= PROD_WIDTH'(in_rgb[(2-gi)*DATA_WIDTH +: DATA_WIDTH])
                          * PROD_WIDTH'(WEIGHTS[gi]);
            end
        end
    end

    assign gray_sum = SUM_WIDTH'(g_ch[0].prod_reg) + SUM_WIDTH'(g_ch[1].prod_reg)
                    + SUM_WIDTH'(g_ch[2].prod_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s1_addr_reg <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
        end else begin
            s1_valid    <= in_valid;
            s1_addr_reg <= in_addr;
            out_valid   <= s1_valid;
            out_addr    <= s1_addr_reg;
            // Weights sum to 256, so the shifted sum never exceeds full scale.
            out_data    <= DATA_WIDTH'(gray_sum >> 8);
        end
    end
endmodule

// File: rtl/rgb2gray_loader.sv
// Loads one grayscale frame into the Sobel input memory, starts Sobel, and
// holds off new pixels until Sobel reports it is done with the frame.
module rgb2gray_loader
    import mem_config_pkg::*;
    import sobel_config_pkg::*;
    import rgb2gray_loader_pkg::*;
#(
    parameter logic [7:0] W_R = GRAY_W_R,
    parameter logic [7:0] W_G = GRAY_W_G,
    parameter logic [7:0] W_B = GRAY_W_B
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rgb2gray_loader_if.slave      s,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  sobel_start_o,
    input  logic                  sobel_finish_i,
    output logic                  frame_err_o,
    output logic                  busy_o
);
    if (weight_sum(W_R, W_G, W_B) != 256) begin : g_bad_weights
        $error("rgb2gray_loader: W_R + W_G + W_B must equal 256");
    end

    typedef enum logic [1:0] {LOAD, DRAIN, START, WAIT_FIN} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] count_reg;
    logic                  ready;
    logic                  transfer;
    logic                  last_pix;
    logic                  s1_valid;

    assign ready       = (state_reg == LOAD);
    assign s.s_ready_o = ready;
    assign busy_o      = !ready;
    assign transfer    = s.s_valid_i & ready;
    assign last_pix    = (count_reg == ADDR_WIDTH'(PIX_COUNT - 1));

    rgb2gray_pipe #(.W_R(W_R), .W_G(W_G), .W_B(W_B)) u_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (transfer),
        .in_rgb    (s.s_rgb_i),
        .in_addr   (count_reg),
        .s1_valid  (s1_valid),
        .out_valid (wr_en_o),
        .out_addr  (wr_addr_o),
        .out_data  (wr_data_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= LOAD;
            count_reg     <= '0;
            sobel_start_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            sobel_start_o <= 1'b0;
            if (transfer && (s.s_last_i != last_pix)) begin
                frame_err_o <= 1'b1;
            end
            case (state_reg)
                LOAD: begin
                    if (transfer) begin
                        if (last_pix) begin
                            count_reg <= '0;
                            state_reg <= DRAIN;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                // With stage 1 empty, the final write leaves stage 2 at this
                // edge, so both valids are clear when START is entered.
                DRAIN: begin
                    if (!s1_valid) begin
                        state_reg     <= START;
                        sobel_start_o <= 1'b1;
                    end
                end
                START: state_reg <= WAIT_FIN;
                WAIT_FIN: begin
                    if (sobel_finish_i) begin
                        state_reg <= LOAD;
                        count_reg <= '0;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb2gray_loader.sv
// Directed bench for rgb2gray_loader with a write/start scoreboard.
module tb_rgb2gray_loader;
    import mem_config_pkg::*;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        int                    cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sobel_finish = 1'b0;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  sobel_start;
    logic                  frame_err;
    logic                  busy;

    rgb2gray_loader_if s_if();

    rgb2gray_loader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .s              (s_if),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .sobel_start_o  (sobel_start),
        .sobel_finish_i (sobel_finish),
        .frame_err_o    (frame_err),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_addr = 0;
    logic err_model = 1'b0;
    exp_t wr_q[$];
    int   start_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gray(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) * 77 + int'(p[15:8]) * 150 + int'(p[7:0]) * 29;
        return 8'(s >> 8);
    endfunction

    // Monitor: one line per observed write or start pulse.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (wr_en) begin
                check("write_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    exp_t e;
                    e = wr_q.pop_front();
                    $display("write cyc=%0d addr=%0d data=%0d", cyc, wr_addr, wr_data);
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("wr_latency", cyc, e.cyc);
                end
            end
            if (sobel_start) begin
                $display("start cyc=%0d", cyc);
                check("start_expected", 32'(start_q.size() != 0), 1);
                if (start_q.size() != 0) check("start_cycle", cyc, start_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called aligned at posedge+1; returns aligned one cycle after the transfer.
    task automatic send(input logic [23:0] rgb, input logic last);
        int   guard;
        exp_t e;
        guard = 0;
        s_if.s_valid_i = 1'b1;
        s_if.s_rgb_i   = rgb;
        s_if.s_last_i  = last;
        while (!s_if.s_ready_o && guard < 200) begin
            step();
            guard++;
        end
        check("send_ready", 32'(s_if.s_ready_o), 1);
        if (s_if.s_ready_o) begin
            e.addr = ADDR_WIDTH'(exp_addr);
            e.data = gray(rgb);
            e.cyc  = cyc + 3;
            wr_q.push_back(e);
            if (last != (exp_addr == 15)) err_model = 1'b1;
            if (exp_addr == 15) begin
                start_q.push_back(cyc + 4);
                exp_addr = 0;
            end else begin
                exp_addr++;
            end
        end
        step();
        s_if.s_valid_i = 1'b0;
        s_if.s_last_i  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((wr_q.size() != 0 || start_q.size() != 0) && guard < 30) begin
            step();
            guard++;
        end
        check("pending_writes", wr_q.size(), 0);
        check("pending_starts", start_q.size(), 0);
    endtask

    task automatic finish_frame();
        sobel_finish = 1'b1;
        step();
        sobel_finish = 1'b0;
    endtask

    initial begin
        logic [23:0] px;
        s_if.s_valid_i = 1'b0;
        s_if.s_rgb_i   = '0;
        s_if.s_last_i  = 1'b0;

        // Reset state
        #12;
        check("rst_ready", 32'(s_if.s_ready_o), 1);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_start", 32'(sobel_start), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        step();

        // Frame 1: colour corners then random pixels, continuous, correct last
        send(24'hFFFFFF, 1'b0);
        send(24'hFF0000, 1'b0);
        send(24'h00FF00, 1'b0);
        send(24'h0000FF, 1'b0);
        for (int i = 4; i < 16; i++) send(24'($urandom), i == 15);
        check("f1_ready_low", 32'(s_if.s_ready_o), 0);
        check("f1_busy", 32'(busy), 1);
        drain();
        check("f1_err", 32'(frame_err), 32'(err_model));

        // Hold-off: valid held in WAIT_FIN, nothing may be written
        px = 24'($urandom);
        s_if.s_valid_i = 1'b1;
        s_if.s_rgb_i   = px;
        repeat (50) step();
        check("holdoff_ready", 32'(s_if.s_ready_o), 0);
        check("holdoff_pending", wr_q.size(), 0);
        finish_frame();
        check("finish_ready", 32'(s_if.s_ready_o), 1);
        check("finish_busy", 32'(busy), 0);

        // Frame 2: early last on the 5th pixel
        send(px, 1'b0);
        for (int i = 1; i < 16; i++) begin
            send(24'($urandom), i == 4);
            if (i == 4) check("early_last_err", 32'(frame_err), 1);
        end
        drain();
        check("f2_err_sticky", 32'(frame_err), 32'(err_model));
        finish_frame();

        // Frame 3: random bubbles on valid
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1) == 0) step();
            send(24'($urandom), i == 15);
        end
        drain();
        check("f3_err_sticky", 32'(frame_err), 1);
        finish_frame();

        // Frame 4: asynchronous reset mid-frame after pixel 7
        for (int i = 0; i < 7; i++) send(24'($urandom), 1'b0);
        check("pre_rst_wr_en", 32'(wr_en), 1);
        #3 rst_n = 1'b0;
        #1;
        wr_q.delete();
        start_q.delete();
        exp_addr  = 0;
        err_model = 1'b0;
        check("arst_wr_en", 32'(wr_en), 0);
        check("arst_ready", 32'(s_if.s_ready_o), 1);
        check("arst_busy", 32'(busy), 0);
        check("arst_err", 32'(frame_err), 0);
        check("arst_start", 32'(sobel_start), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        step();

        // Frame 5: fresh frame from address 0
        for (int i = 0; i < 16; i++) send(24'($urandom), i == 15);
        drain();
        check("f5_err", 32'(frame_err), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
